// File: rtl/prbs9_checker_if.sv
// -----------------------------------------------------------------------------
// prbs9_checker_if
// Bundles the serial-bit stream and the status/counter outputs of the PRBS9
// checker into one connection.
//   enable      : bit_in is valid this cycle
//   bit_in      : received serial bit
//   clear       : synchronous zeroing of bit_count / error_count
//   locked      : checker is synchronised to the PRBS9 stream
//   sync_loss   : one-cycle pulse when synchronisation is lost
//   bit_count   : bits checked while locked (saturating)
//   error_count : mismatching bits while locked (saturating)
// Modports: master drives the stream and reads status; slave is the checker.
// -----------------------------------------------------------------------------
interface prbs9_checker_if #(
    parameter int CNT_W = 32
) ();
    logic             enable;
    logic             bit_in;
    logic             clear;
    logic             locked;
    logic             sync_loss;
    logic [CNT_W-1:0] bit_count;
    logic [CNT_W-1:0] error_count;

    modport master (
        output enable,
        output bit_in,
        output clear,
        input  locked,
        input  sync_loss,
        input  bit_count,
        input  error_count
    );

    modport slave (
        input  enable,
        input  bit_in,
        input  clear,
        output locked,
        output sync_loss,
        output bit_count,
        output error_count
    );
endinterface

// File: rtl/prbs9_checker.sv
// -----------------------------------------------------------------------------
// prbs9_checker
// Synchronises to a PRBS9 stream x[k] = NOT(x[k-9] XOR x[k-5]) and counts bit
// errors once locked.
//   SEARCH : history is loaded from the received bits; after LOCK_COUNT
//            consecutive correctly predicted bits the checker locks.
//   LOCKED : history runs free on its own predictions, so a single received
//            error is counted once and does not corrupt later predictions.
//            UNLOCK_ERRS errors inside one WINDOW-bit window drop back to SEARCH.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : prbs9_checker_if.slave (enable, bit_in, clear in; locked,
//           sync_loss, bit_count, error_count out -- all outputs registered)
// -----------------------------------------------------------------------------
module prbs9_checker #(
    parameter int LOCK_COUNT  = 32,
    parameter int WINDOW      = 64,
    parameter int UNLOCK_ERRS = 8,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    prbs9_checker_if.slave       bus
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int WERR_W  = $clog2(UNLOCK_ERRS + 1);
    localparam logic [3:0] FILL_FULL = 4'd9;

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_q,       state_d;
    logic [8:0]         h_q,           h_d;
    logic [3:0]         fill_q,        fill_d;
    logic [MATCH_W-1:0] match_q,       match_d;
    logic [WIN_W-1:0]   win_cnt_q,     win_cnt_d;
    logic [WERR_W-1:0]  win_err_q,     win_err_d;
    logic               locked_q,      locked_d;
    logic               sync_loss_q,   sync_loss_d;
    logic [CNT_W-1:0]   bit_count_q,   bit_count_d;
    logic [CNT_W-1:0]   error_count_q, error_count_d;

    logic               pred_s;
    logic               bit_err_s;
    logic [WERR_W-1:0]  win_err_inc_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    // Next-state logic for the search/lock machine, window tracking and counters.
    always_comb begin
        pred_s        = ~(h_q[8] ^ h_q[4]);
        bit_err_s     = 1'b0;
        win_err_inc_s = win_err_q + WERR_W'(1);

        state_d       = state_q;
        h_d           = h_q;
        fill_d        = fill_q;
        match_d       = match_q;
        win_cnt_d     = win_cnt_q;
        win_err_d     = win_err_q;
        locked_d      = locked_q;
        sync_loss_d   = 1'b0;
        bit_count_d   = bit_count_q;
        error_count_d = error_count_q;

        if (bus.enable) begin
            case (state_q)
                ST_SEARCH: begin
                    h_d = {h_q[7:0], bus.bit_in};
                    if (fill_q != FILL_FULL) begin
                        fill_d = fill_q + 4'd1;
                    end else begin
                        fill_d = fill_q;
                    end
                    // All-ones history is the generator lock-up pattern and
                    // predicts 1 forever, so it must never build up a match run.
                    if ((fill_q == FILL_FULL) && (h_q != 9'h1FF) && (bus.bit_in == pred_s)) begin
                        match_d = match_q + MATCH_W'(1);
                    end else begin
                        match_d = '0;
                    end
                    if (match_d == MATCH_W'(LOCK_COUNT)) begin
                        state_d   = ST_LOCKED;
                        locked_d  = 1'b1;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        state_d   = ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    // Free-running reference: shift in the prediction, not the
                    // received bit, so one bad bit yields exactly one error.
                    h_d         = {h_q[7:0], pred_s};
                    bit_err_s   = (bus.bit_in != pred_s);
                    bit_count_d = sat_inc(bit_count_q);
                    if (bit_err_s) begin
                        error_count_d = sat_inc(error_count_q);
                    end else begin
                        error_count_d = error_count_q;
                    end
                    // Loss-of-sync test takes priority over the window wrap so
                    // an error on the last bit of a window still counts.
                    if (bit_err_s && (win_err_inc_s >= WERR_W'(UNLOCK_ERRS))) begin
                        state_d     = ST_SEARCH;
                        locked_d    = 1'b0;
                        sync_loss_d = 1'b1;
                        fill_d      = 4'd0;
                        match_d     = '0;
                        win_cnt_d   = '0;
                        win_err_d   = '0;
                    end else if (win_cnt_q == WIN_W'(WINDOW - 1)) begin
                        win_cnt_d   = '0;
                        win_err_d   = '0;
                    end else begin
                        win_cnt_d   = win_cnt_q + WIN_W'(1);
                        if (bit_err_s) begin
                            win_err_d = win_err_inc_s;
                        end else begin
                            win_err_d = win_err_q;
                        end
                    end
                end
                default: begin
                    state_d  = ST_SEARCH;
                    locked_d = 1'b0;
                    fill_d   = 4'd0;
                    match_d  = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // Clear wins over any increment on the same cycle.
        if (bus.clear) begin
            bit_count_d   = '0;
            error_count_d = '0;
        end else begin
            bit_count_d   = bit_count_d;
            error_count_d = error_count_d;
        end
    end

    // State, history, counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_SEARCH;
            h_q           <= 9'd0;
            fill_q        <= 4'd0;
            match_q       <= '0;
            win_cnt_q     <= '0;
            win_err_q     <= '0;
            locked_q      <= 1'b0;
            sync_loss_q   <= 1'b0;
            bit_count_q   <= '0;
            error_count_q <= '0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            fill_q        <= fill_d;
            match_q       <= match_d;
            win_cnt_q     <= win_cnt_d;
            win_err_q     <= win_err_d;
            locked_q      <= locked_d;
            sync_loss_q   <= sync_loss_d;
            bit_count_q   <= bit_count_d;
            error_count_q <= error_count_d;
        end
    end

    assign bus.locked      = locked_q;
    assign bus.sync_loss   = sync_loss_q;
    assign bus.bit_count   = bit_count_q;
    assign bus.error_count = error_count_q;

endmodule
